// File: rtl/mem_access_unit.sv
// mem_access_unit: 4 KB little-endian data memory with byte/half/word stores and 1-cycle loads (MEM_ALIGN_CHECK_EN: trap misaligned accesses)
module mem_access_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        SignExt,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic        MisalignErr
);
  logic [31:0] mem [1024] = '{default: '0};
  logic [9:0]  idx;
  logic [1:0]  lane;
  logic        misalign, sized, wr, rd;
  logic [3:0]  be;
  logic [31:0] wdata, shifted, load;
  assign idx   = Address[11:2];
  assign sized = MemSize != 2'b11;
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (MemSize == 2'b00 && Address[1:0] != 2'b00) || (MemSize == 2'b01 && Address[0]);
  assign lane     = Address[1:0];
`else
  assign misalign = 1'b0;
  assign lane     = MemSize == 2'b00 ? 2'b00 : MemSize == 2'b01 ? {Address[1], 1'b0} : Address[1:0];
`endif
  // request decode, lane enables, store replication and load extraction
  always_comb begin
    wr      = !Rst && MemWrite && sized && !misalign;
    rd      = !Rst && MemRead && !MemWrite && sized;
    be      = MemSize == 2'b00 ? 4'hF : MemSize == 2'b01 ? (lane[1] ? 4'hC : 4'h3) : 4'b0001 << lane;
    wdata   = MemSize == 2'b00 ? WriteData : MemSize == 2'b01 ? {2{WriteData[15:0]}} : {4{WriteData[7:0]}};
    shifted = mem[idx] >> {lane, 3'b000};
    load    = misalign ? '0 :
              MemSize == 2'b00 ? shifted :
              MemSize == 2'b01 ? {{16{SignExt & shifted[15]}}, shifted[15:0]} :
                                 {{24{SignExt & shifted[7]}}, shifted[7:0]};
  end
  // byte-lane masked store; storage is deliberately untouched by reset
  always_ff @(posedge Clk) begin
    if (wr)
      for (int n = 0; n < 4; n++)
        if (be[n]) mem[idx][8*n +: 8] <= wdata[8*n +: 8];
  end
  // registered load result and valid pulse; data holds between loads
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ReadData  <= '0;
      ReadValid <= 1'b0;
    end else begin
      ReadValid <= rd;
      if (rd) ReadData <= load;
    end
  end
`ifdef MEM_ALIGN_CHECK_EN
  // misalignment pulse, aligned in time with ReadValid
  always_ff @(posedge Clk) begin
    if (Rst) MisalignErr <= 1'b0;
    else MisalignErr <= (MemRead || MemWrite) && sized && misalign;
  end
`else
  assign MisalignErr = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: byte-array reference model with per-cycle compare, directed scenarios and random traffic
module tb_mem_access_unit;
  logic        Clk = 1'b0, Rst = 1'b1;
  logic [31:0] Address = '0, WriteData = '0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, SignExt = 1'b0;
  logic [1:0]  MemSize = 2'b00;
  logic [31:0] ReadData;
  logic        ReadValid, MisalignErr;
  int          errors = 0, checks = 0;
  logic        live = 1'b0;
  logic [7:0]  emem [4096];
  logic [31:0] erd = '0;
  logic        erv = 1'b0, eme = 1'b0;

  mem_access_unit dut (
    .Clk(Clk), .Rst(Rst), .Address(Address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .SignExt(SignExt),
    .ReadData(ReadData), .ReadValid(ReadValid), .MisalignErr(MisalignErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: memory as 4096 bytes, accesses as byte loops
  always @(posedge Clk) begin
    int nb, a;
    logic mis, acc;
    logic [31:0] v;
    if (Rst) begin
      erd = '0; erv = 1'b0; eme = 1'b0;
    end else begin
      nb  = MemSize == 2'b00 ? 4 : MemSize == 2'b01 ? 2 : 1;
      a   = int'(Address[11:0]);
      mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis = MemSize != 2'b11 && (a % nb) != 0;
`else
      a = a - (a % nb);
`endif
      acc = (MemRead || MemWrite) && MemSize != 2'b11;
      eme = acc && mis;
      erv = MemRead && !MemWrite && MemSize != 2'b11;
      if (MemWrite && MemSize != 2'b11 && !mis) begin
        for (int i = 0; i < nb; i++) emem[a + i] = WriteData[8*i +: 8];
      end else if (erv) begin
        v = '0;
        if (!mis) begin
          for (int i = 0; i < nb; i++) v[8*i +: 8] = emem[a + i];
          if (SignExt && nb < 4 && v[8*nb - 1]) v = v | (32'hFFFF_FFFF << (8*nb));
        end
        erd = v;
      end
    end
  end

  always @(negedge Clk) begin
    if (live) begin
      chk("model ReadValid", {31'b0, ReadValid}, {31'b0, erv});
      chk("model MisalignErr", {31'b0, MisalignErr}, {31'b0, eme});
      chk("model ReadData", ReadData, erd);
    end
  end

  task automatic op(input logic r, input logic w, input logic [1:0] sz, input logic se,
                    input logic [31:0] a, input logic [31:0] d);
    MemRead = r; MemWrite = w; MemSize = sz; SignExt = se; Address = a; WriteData = d;
    @(negedge Clk);
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    foreach (emem[i]) emem[i] = 8'h00;
    @(negedge Clk);
    @(negedge Clk);
    live = 1'b1;
    chk("reset ReadData", ReadData, 32'h0);
    chk("reset ReadValid", {31'b0, ReadValid}, 32'h0);
    chk("reset MisalignErr", {31'b0, MisalignErr}, 32'h0);
    Rst = 1'b0;
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF);
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    chk("lw after sw data", ReadData, 32'hDEADBEEF);
    chk("lw after sw valid", {31'b0, ReadValid}, 32'h1);
    idle();
    chk("valid drops", {31'b0, ReadValid}, 32'h0);
    chk("data holds", ReadData, 32'hDEADBEEF);
    op(1'b0, 1'b1, 2'b10, 1'b0, 32'h21, 32'h80);
    op(1'b1, 1'b0, 2'b10, 1'b1, 32'h21, 32'h0);
    chk("lb signed", ReadData, 32'hFFFFFF80);
    op(1'b1, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0);
    chk("lb unsigned", ReadData, 32'h00000080);
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    chk("lw after sb", ReadData, 32'h00008000);
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h30, 32'hAAAAAAAA);
    op(1'b0, 1'b1, 2'b01, 1'b0, 32'h32, 32'h1234);
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h30, 32'h0);
    chk("lw after sh", ReadData, 32'h1234AAAA);
    op(1'b1, 1'b0, 2'b01, 1'b1, 32'h32, 32'h0);
    chk("lh signed", ReadData, 32'h00001234);
    op(1'b1, 1'b1, 2'b00, 1'b0, 32'h40, 32'h5);
    chk("rw both valid", {31'b0, ReadValid}, 32'h0);
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0);
    chk("lw after rw", ReadData, 32'h00000005);
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h1040, 32'h9);
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0);
    chk("wrap", ReadData, 32'h00000009);
    op(1'b1, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    chk("reserved size valid", {31'b0, ReadValid}, 32'h0);
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h50, 32'h11);
    Rst = 1'b1;
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h50, 32'h77);
    chk("reset clears data", ReadData, 32'h0);
    Rst = 1'b0;
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h50, 32'h0);
    chk("store dropped in reset", ReadData, 32'h00000011);
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hCAFEF00D);
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    chk("misaligned lw data", ReadData, 32'h0);
    chk("misaligned lw err", {31'b0, MisalignErr}, 32'h1);
`else
    chk("forced-align lw data", ReadData, 32'hCAFEF00D);
    chk("forced-align lw err", {31'b0, MisalignErr}, 32'h0);
`endif
    chk("odd lw valid", {31'b0, ReadValid}, 32'h1);
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : {$urandom_range(0, 1048575) & 32'hFFFFF, 6'd0, 6'($urandom_range(0, 63))};
      Rst = $urandom_range(0, 49) == 0;
      op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end
    Rst = 1'b0;
    idle();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: Clk  in  1  rising-edge clock for all state.
REQ-002 Rst  in  1  synchronous, active-high reset.
REQ-003 Address  in  32  byte address from the ALU result (add of base + offset).
REQ-004 WriteData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-005 MemRead  in  1  load request this cycle.
REQ-006 MemWrite  in  1  store request this cycle.
REQ-007 MemSize  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved.
REQ-008 SignExt  in  1  loads only: 1 sign-extends (lh/lb), 0 zero-extends.
REQ-009 ReadData  out  32  registered load result, right-aligned and extended.
REQ-010 ReadValid  out  1  one-cycle pulse marking ReadData as a new load result.
REQ-011 MisalignErr  out  1  one-cycle pulse on a rejected misaligned access.

Function
REQ-012 Storage SHALL be 1024 x 32-bit words (4 KB), indexed by Address[11:2]; Address[31:12] ignored, so addresses wrap modulo 4 KB.
REQ-013 Byte lanes SHALL be little-endian: lane n = word bits [8n+7:8n], with lane = Address[1:0] and half select = Address[1].
REQ-014 Store, MemWrite=1, MemSize=00: full word written on the rising edge.
REQ-015 Store, MemSize=01: WriteData[15:0] written to the selected half; other half unchanged.
REQ-016 Store, MemSize=10: WriteData[7:0] written to the selected lane; other three lanes unchanged.
REQ-017 Load latency SHALL be exactly 1 cycle: with MemRead=1 sampled at edge N, ReadData and ReadValid=1 appear after edge N.
REQ-018 ReadValid SHALL be 0 in every cycle not following an accepted load.
REQ-019 ReadData SHALL hold its last value while ReadValid=0.
REQ-020 Load extraction: word = full word; half = selected 16 bits; byte = selected 8 bits; extension per SignExt.
REQ-021 A load at edge N+1 from an address stored at edge N SHALL return the new data (write-then-read coherent).
REQ-022 MemRead and MemWrite both 1: the store SHALL be performed, the load suppressed, and ReadValid SHALL stay 0.
REQ-023 MemSize=11: no write, ReadValid=0, MisalignErr=0 (treated as no access).
REQ-024 Reads SHALL NOT modify storage; a cycle with MemRead=MemWrite=0 changes nothing except deasserting the pulses.

Reset
REQ-025 With Rst=1 at a rising edge: ReadData=0, ReadValid=0, MisalignErr=0.
REQ-026 With Rst=1 at a rising edge, any store or load requested that cycle SHALL be suppressed.
REQ-027 Reset SHALL NOT clear storage contents; simulation initial contents are all-zero.
REQ-028 An access presented in the first cycle after Rst falls SHALL be handled normally.

Configuration
REQ-029 Macro MEM_ALIGN_CHECK_EN defined: a word access with Address[1:0]!=00, or a half access with Address[0]=1, is misaligned.
REQ-030 With MEM_ALIGN_CHECK_EN defined, a misaligned access SHALL suppress the store.
REQ-031 With MEM_ALIGN_CHECK_EN defined, a misaligned load SHALL return ReadData=0 with ReadValid=1.
REQ-032 With MEM_ALIGN_CHECK_EN defined, a misaligned access SHALL pulse MisalignErr=1 one cycle after the request, with the same timing as ReadValid.
REQ-033 MEM_ALIGN_CHECK_EN undefined: word accesses SHALL force Address[1:0] to 00 and half accesses SHALL force Address[0] to 0.
REQ-034 MEM_ALIGN_CHECK_EN undefined: MisalignErr SHALL be tied to 0.

Verification
REQ-035 sw 0xDEADBEEF @0x10, then lw @0x10 next cycle -> ReadData=0xDEADBEEF and ReadValid=1 one cycle after the lw, 0 the cycle after.
REQ-036 sb 0x80 @0x21 over word 0x00000000, then lb SignExt=1 @0x21 -> 0xFFFFFF80; lb SignExt=0 -> 0x00000080; lw @0x20 -> 0x00008000.
REQ-037 sh 0x1234 @0x32 over word 0xAAAAAAAA -> lw @0x30 reads 0x1234AAAA; lh @0x32 SignExt=1 -> 0x00001234.
REQ-038 MemRead=MemWrite=1, sw 0x5 @0x40 -> ReadValid stays 0; later lw @0x40 -> 0x00000005; sw @0x1040 then lw @0x40 shows wrap.
REQ-039 Rst=1 in the same cycle as sw 0x77 @0x50 (prior 0x11) -> outputs 0, the store is dropped, and lw @0x50 after reset -> 0x00000011.
REQ-040 lw @0x13, macro defined -> ReadData=0, ReadValid=1, MisalignErr=1; macro undefined -> word @0x10 returned and MisalignErr=0.
